// File: rtl/mem_wb_stage.sv
// mem_wb_stage: rv32i writeback stage.
// Captures instructions leaving the memory stage, waits for the data-memory
// response on loads, extracts/extends load data and presents one register-file
// write per retired instruction. Stalls the memory stage while a load is open.
// Optional feature macro: MEM_WB_INSTRET_EN adds a 64-bit retired-instruction
// counter on port instret.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        wb_ready,
  input  logic        mem_load_regfile,
  input  logic [3:0]  mem_regfilemux_sel,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_out,
  input  logic        mem_br_en,
  input  logic [31:0] mem_u_imm,
  input  logic [31:0] mem_pc,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_wb,
  output logic        load_regfile_wb,
  output logic [31:0] regfilemux_out_wb
`ifdef MEM_WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        lr_q, lr_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic        br_q, br_d;
  logic [31:0] uimm_q, uimm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;

  logic        capture;
  logic        capture_is_load;
  logic        holding;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] wb_value;

  // Only a pending load response blocks new instructions.
  assign wb_ready = (state_q != ST_WAIT);
  assign capture  = mem_valid && wb_ready;
  assign holding  = (state_q == ST_HOLD);

  // Decode whether the incoming instruction needs a data-memory response.
  always_comb begin
    capture_is_load = 1'b0;
    case (mem_regfilemux_sel)
      4'd3, 4'd5, 4'd6, 4'd7, 4'd8: capture_is_load = 1'b1;
      default:                      capture_is_load = 1'b0;
    endcase
  end

  // Next-state and held-field update; dmem_resp only matters in WAIT.
  always_comb begin
    state_d = state_q;
    lr_d    = lr_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    br_d    = br_q;
    uimm_d  = uimm_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_EMPTY, ST_HOLD: begin
        if (capture) begin
          lr_d    = mem_load_regfile;
          sel_d   = mem_regfilemux_sel;
          rd_d    = mem_rd;
          alu_d   = mem_alu_out;
          br_d    = mem_br_en;
          uimm_d  = mem_u_imm;
          pc_d    = mem_pc;
          state_d = capture_is_load ? ST_WAIT : ST_HOLD;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT: begin
        if (dmem_resp) begin
          rdata_d = dmem_rdata;
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Load lane extraction and writeback source select from held registers.
  always_comb begin
    load_byte = rdata_q[{alu_q[1:0], 3'b000} +: 8];
    load_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    wb_value  = 32'd0;
    case (sel_q)
      4'd0: wb_value = alu_q;
      4'd1: wb_value = {31'd0, br_q};
      4'd2: wb_value = uimm_q;
      4'd3: wb_value = rdata_q;
      4'd4: wb_value = pc_q + 32'd4;
      4'd5: wb_value = {{24{load_byte[7]}}, load_byte};
      4'd6: wb_value = {24'd0, load_byte};
      4'd7: wb_value = {{16{load_half[15]}}, load_half};
      4'd8: wb_value = {16'd0, load_half};
      default: wb_value = 32'd0;
    endcase
  end

  // Register-file port is driven only while an instruction is held.
  always_comb begin
    rd_wb             = holding ? rd_q : 5'd0;
    load_regfile_wb   = holding && lr_q && (rd_q != 5'd0);
    regfilemux_out_wb = holding ? wb_value : 32'd0;
  end

  // State and held-field registers; reset drops any outstanding load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      lr_q    <= 1'b0;
      sel_q   <= 4'd0;
      rd_q    <= 5'd0;
      alu_q   <= 32'd0;
      br_q    <= 1'b0;
      uimm_q  <= 32'd0;
      pc_q    <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      lr_q    <= lr_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      br_q    <= br_d;
      uimm_q  <= uimm_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Every HOLD cycle is exactly one retirement, write or not.
  always_comb begin
    instret_d = instret_q + {63'd0, holding};
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases plus randomized instruction
// stream, checked against a transaction-level writeback model.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        wb_ready;
  logic        mem_load_regfile;
  logic [3:0]  mem_regfilemux_sel;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_out;
  logic        mem_br_en;
  logic [31:0] mem_u_imm;
  logic [31:0] mem_pc;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_wb;
  logic        load_regfile_wb;
  logic [31:0] regfilemux_out_wb;
`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  mem_wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid         (mem_valid),
    .wb_ready          (wb_ready),
    .mem_load_regfile  (mem_load_regfile),
    .mem_regfilemux_sel(mem_regfilemux_sel),
    .mem_rd            (mem_rd),
    .mem_alu_out       (mem_alu_out),
    .mem_br_en         (mem_br_en),
    .mem_u_imm         (mem_u_imm),
    .mem_pc            (mem_pc),
    .dmem_resp         (dmem_resp),
    .dmem_rdata        (dmem_rdata),
    .rd_wb             (rd_wb),
    .load_regfile_wb   (load_regfile_wb),
    .regfilemux_out_wb (regfilemux_out_wb)
`ifdef MEM_WB_INSTRET_EN
    ,
    .instret           (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected behaviour for the current cycle.
  logic        exp_hold  = 1'b0;
  logic        exp_ready = 1'b1;
  logic [4:0]  exp_rd    = 5'd0;
  logic        exp_we    = 1'b0;
  logic [31:0] exp_data  = 32'd0;
  longint unsigned retired = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [31:0] ref_wb(input logic [3:0] sel, input logic [31:0] alu,
                                         input logic br, input logic [31:0] uimm,
                                         input logic [31:0] pc, input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (alu % 4))) & 32'hFF;
    h = (rdata >> (16 * ((alu / 2) % 2))) & 32'hFFFF;
    case (sel)
      4'd0: return alu;
      4'd1: return br ? 32'd1 : 32'd0;
      4'd2: return uimm;
      4'd3: return rdata;
      4'd4: return pc + 32'd4;
      4'd5: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      4'd6: return b;
      4'd7: return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      4'd8: return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_load_sel(input logic [3:0] sel);
    return (sel == 4'd3) || (sel >= 4'd5 && sel <= 4'd8);
  endfunction

  // One clock: check outputs mid-cycle, then advance past the edge.
  task automatic cycle();
    @(negedge clk);
    check("wb_ready", 64'(wb_ready), 64'(exp_ready));
    if (exp_hold) begin
      check("rd_wb", 64'(rd_wb), 64'(exp_rd));
      check("load_regfile_wb", 64'(load_regfile_wb), 64'(exp_we));
      if (exp_we) check("wb_data", 64'(regfilemux_out_wb), 64'(exp_data));
    end else begin
      check("idle_rd", 64'(rd_wb), 64'd0);
      check("idle_we", 64'(load_regfile_wb), 64'd0);
      check("idle_data", 64'(regfilemux_out_wb), 64'd0);
    end
`ifdef MEM_WB_INSTRET_EN
    check("instret", instret, retired);
`endif
    @(posedge clk);
    if (exp_hold) retired++;
    #1;
    exp_hold  = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Present one instruction, service its load response, then idle `gap` cycles.
  task automatic send(input logic [3:0] sel, input logic [4:0] rd, input logic lr,
                      input logic [31:0] alu, input logic br, input logic [31:0] uimm,
                      input logic [31:0] pc, input logic [31:0] rdata,
                      input int delay, input int gap);
    mem_valid          = 1'b1;
    mem_regfilemux_sel = sel;
    mem_rd             = rd;
    mem_load_regfile   = lr;
    mem_alu_out        = alu;
    mem_br_en          = br;
    mem_u_imm          = uimm;
    mem_pc             = pc;
    dmem_resp          = 1'($urandom % 2);
    dmem_rdata         = $urandom;
    cycle();
    if (is_load_sel(sel)) begin
      for (int i = 0; i < delay; i++) begin
        mem_valid          = 1'($urandom % 2);
        mem_regfilemux_sel = 4'($urandom);
        mem_rd             = 5'($urandom);
        mem_alu_out        = $urandom;
        dmem_resp          = 1'b0;
        dmem_rdata         = $urandom;
        exp_ready          = 1'b0;
        cycle();
      end
      mem_valid  = 1'($urandom % 2);
      dmem_resp  = 1'b1;
      dmem_rdata = rdata;
      exp_ready  = 1'b0;
      cycle();
    end
    mem_valid  = 1'b0;
    dmem_resp  = 1'($urandom % 2);
    dmem_rdata = $urandom;
    exp_hold   = 1'b1;
    exp_rd     = rd;
    exp_we     = lr && (rd != 5'd0);
    exp_data   = ref_wb(sel, alu, br, uimm, pc, rdata);
    $display("txn sel=%0d rd=%0d lr=%0b alu=0x%08h delay=%0d -> data 0x%08h", sel, rd, lr, alu,
             delay, exp_data);
    for (int i = 0; i < gap; i++) begin
      cycle();
      dmem_resp = 1'($urandom % 2);
    end
  endtask

  initial begin
    rst                = 1'b1;
    mem_valid          = 1'b0;
    mem_load_regfile   = 1'b0;
    mem_regfilemux_sel = 4'd0;
    mem_rd             = 5'd0;
    mem_alu_out        = 32'd0;
    mem_br_en          = 1'b0;
    mem_u_imm          = 32'd0;
    mem_pc             = 32'd0;
    dmem_resp          = 1'b0;
    dmem_rdata         = 32'd0;
    #2;
    check("reset_ready", 64'(wb_ready), 64'd1);
    check("reset_rd", 64'(rd_wb), 64'd0);
    check("reset_we", 64'(load_regfile_wb), 64'd0);
    check("reset_data", 64'(regfilemux_out_wb), 64'd0);
`ifdef MEM_WB_INSTRET_EN
    check("reset_instret", instret, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases.
    send(4'd0, 5'd5, 1'b1, 32'h1234, 1'b0, 32'd0, 32'd0, 32'd0, 0, 2);
    send(4'd2, 5'd0, 1'b1, 32'd0, 1'b0, 32'hABCDE000, 32'd0, 32'd0, 0, 1);
    send(4'd5, 5'd9, 1'b1, 32'h103, 1'b0, 32'd0, 32'd0, 32'h80FF7F01, 2, 1);
    send(4'd8, 5'd10, 1'b1, 32'h102, 1'b0, 32'd0, 32'd0, 32'h80FF7F01, 1, 1);
    send(4'd4, 5'd1, 1'b1, 32'd0, 1'b0, 32'd0, 32'h60, 32'd0, 0, 0);
    send(4'd1, 5'd2, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0, 32'd0, 0, 0);
    send(4'd0, 5'd3, 1'b1, 32'hCAFE0001, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1);
    send(4'd7, 5'd4, 1'b1, 32'h7, 1'b0, 32'd0, 32'd0, 32'h9ABC1234, 0, 0);
    send(4'd12, 5'd6, 1'b1, 32'h55, 1'b1, 32'h1, 32'h2, 32'd0, 0, 1);

    // Asynchronous reset while a load is outstanding.
    mem_valid          = 1'b1;
    mem_regfilemux_sel = 4'd3;
    mem_rd             = 5'd7;
    mem_load_regfile   = 1'b1;
    dmem_resp          = 1'b0;
    cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    check("wait_ready", 64'(wb_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 64'(wb_ready), 64'd1);
    check("arst_rd", 64'(rd_wb), 64'd0);
    check("arst_we", 64'(load_regfile_wb), 64'd0);
    check("arst_data", 64'(regfilemux_out_wb), 64'd0);
    retired = 0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h12345678;
    cycle();
    dmem_resp = 1'b0;
    cycle();

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] rd;
      int gap;
      rd  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      gap = (($urandom % 2) == 0) ? 0 : int'($urandom_range(1, 2));
      send(4'($urandom), rd, 1'($urandom % 4 != 0), $urandom, 1'($urandom),
           $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), gap);
    end
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
